windowed_regfile: RTL and testbench
===================================

WINDOWED_REGFILE -- requirements
Module: windowed_regfile

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8, meaning the number of register windows (legal range 2..32).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the data width of each register.
REQ-003 SHALL have parameter CWPW, default 5, meaning the CWP field width; it SHALL be at least clog2(NWINDOWS).
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on posedge Clk.
REQ-005 SHALL have port Clr_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports RA and RB, input, 5 bits each: architectural read addresses r0..r31.
REQ-007 SHALL have ports PortA and PortB, output, WIDTH bits each: combinational read data.
REQ-008 SHALL have ports RC (input, 5 bits), PortC (input, WIDTH bits) and Ld (input, 1 bit): write address, write data and write enable.
REQ-009 SHALL have ports Save and Restore, input, 1 bit each: window-shift requests.
REQ-010 SHALL have ports CwpLd (input, 1 bit) and CwpIn (input, CWPW bits): direct CWP load, as for a PSR write.
REQ-011 SHALL have port WIM, input, NWINDOWS bits: the window invalid mask.
REQ-012 SHALL have port CWP, output, CWPW bits: the current window pointer.
REQ-013 SHALL have ports WOvf, WUnf and WErr, output, 1 bit each: overflow, underflow and conflict pulses.

Function
REQ-014 Physical storage SHALL be 8 globals plus NWINDOWS*16 windowed registers, all WIDTH bits.
REQ-015 Address r1..r7 SHALL map to global[r].
REQ-016 Address r8..r31 SHALL map to windowed[(CWP*16 + r-8) mod (NWINDOWS*16)], so the ins of window w alias the outs of window w+1.
REQ-017 A read of r0 SHALL return 0.
REQ-018 Any other read SHALL return the mapped register, reflecting writes from earlier cycles only; there is no write-to-read bypass in the same cycle.
REQ-019 When Ld=1 and RC!=0, the block SHALL write PortC to the mapped register at posedge.
REQ-020 A write to r0 SHALL be ignored.
REQ-021 A write SHALL use the CWP value held before any same-cycle window change.
REQ-022 Save SHALL compute new = (CWP-1) mod NWINDOWS.
REQ-023 On Save, if WIM[new]=1, CWP SHALL be unchanged and WOvf SHALL pulse high for 1 cycle; otherwise CWP SHALL become new.
REQ-024 Restore SHALL compute new = (CWP+1) mod NWINDOWS.
REQ-025 On Restore, if WIM[new]=1, CWP SHALL be unchanged and WUnf SHALL pulse high for 1 cycle; otherwise CWP SHALL become new.
REQ-026 Wrap-around SHALL be exact: Save at CWP=0 targets NWINDOWS-1, and Restore at CWP=NWINDOWS-1 targets 0.
REQ-027 Save=Restore=1 in the same cycle SHALL be a no-op on CWP and SHALL pulse WErr for 1 cycle.
REQ-028 CwpLd SHALL have priority over Save and Restore: CWP SHALL take CwpIn mod NWINDOWS, and no trap pulse SHALL be raised.
REQ-029 WOvf, WUnf and WErr SHALL be registered, asserted in the cycle after the request, and never held for more than 1 cycle without a new request.
REQ-030 The CWP update SHALL take effect on the cycle after the request, so reads in that next cycle use the new window.

Reset
REQ-031 When Clr_n=0 at posedge, the block SHALL clear CWP, WOvf, WUnf and WErr to 0.
REQ-032 When Clr_n=0 at posedge, the block SHALL clear all globals and all windowed registers to 0.
REQ-033 Reset SHALL override Ld, Save, Restore and CwpLd in the same cycle.
REQ-034 A reset asserted mid-sequence SHALL abandon any pending pulse.

Structure
REQ-035 A shared package SHALL hold the constants NGLOBALS=8, WINREGS=16 and the address-field width 5.
REQ-036 A shared package SHALL hold the physical-index function (CWP, r) -> index, which the bench shares.
REQ-037 One sub-module, windowed_regfile_cwp, SHALL hold the CWP register, the mod-NWINDOWS arithmetic, the WIM check and the trap pulse flops.
REQ-038 Storage and read muxing SHALL stay in the top module.

Verification
REQ-039 Reset, then read all r0..r31 -> all 0, CWP=0, all pulse outputs 0.
REQ-040 With CWP=0, write r8=0xAAAA0008, then Save with WIM=0 -> CWP=7 (NWINDOWS=8), and reading r24 returns 0xAAAA0008.
REQ-041 With CWP=0, WIM=8'h80, Save -> CWP stays 0, WOvf=1 for exactly 1 cycle; then Restore with WIM=8'h02 -> CWP stays 0, WUnf pulses.
REQ-042 Write r3=0x1234 in window 0, CwpLd to 5 -> r3 reads 0x1234; write r0=0xFFFF -> r0 reads 0.
REQ-043 Save=Restore=1 together -> WErr pulses and CWP is unchanged; Save with CwpLd=1 and CwpIn=2 -> CWP=2 and no WOvf.
REQ-044 Ld=1, RC=16, PortC=0x55 together with Save at CWP=3 -> the write lands in window 3 locals and CWP becomes 2; Clr_n=0 during a pending Save -> CWP=0 and no pulse.

Source files
------------

// File: rtl/windowed_regfile_pkg.sv
// Shared constants and the architectural-to-physical register mapping
// used by the windowed register file and its bench.
package windowed_regfile_pkg;

    localparam int unsigned NGLOBALS = 8;
    localparam int unsigned WINREGS  = 16;
    localparam int unsigned AW       = 5;

    // Physical windowed index for address r (r >= NGLOBALS) in window cwp;
    // the wrap makes the ins of window w alias the outs of window w+1.
    function automatic int unsigned win_index(input int unsigned cwp,
                                              input int unsigned r,
                                              input int unsigned nwindows);
        return (cwp * WINREGS + r - NGLOBALS) % (nwindows * WINREGS);
    endfunction

endpackage

// File: rtl/windowed_regfile_cwp.sv
// Current-window-pointer register with save/restore/load handling,
// WIM trap detection and single-cycle trap pulses.
module windowed_regfile_cwp #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned CWPW     = 5
) (
    input  logic                Clk,
    input  logic                Clr_n,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CwpLd,
    input  logic [CWPW-1:0]     CwpIn,
    input  logic [NWINDOWS-1:0] WIM,
    output logic [CWPW-1:0]     CWP,
    output logic                WOvf,
    output logic                WUnf,
    output logic                WErr
);

    localparam logic [CWPW-1:0] LAST = CWPW'(NWINDOWS - 1);

    logic [CWPW-1:0]     cwp_q;
    logic [CWPW-1:0]     save_tgt;
    logic [CWPW-1:0]     rest_tgt;
    logic [CWPW-1:0]     load_val;
    logic [NWINDOWS-1:0] wim_save;
    logic [NWINDOWS-1:0] wim_rest;

    always_comb begin
        save_tgt = (cwp_q == '0)   ? LAST : cwp_q - CWPW'(1);
        rest_tgt = (cwp_q == LAST) ? '0   : cwp_q + CWPW'(1);
        load_val = CWPW'(32'(CwpIn) % NWINDOWS);
        // Shift rather than bit-select so the index width never matters.
        wim_save = WIM >> save_tgt;
        wim_rest = WIM >> rest_tgt;
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            cwp_q <= '0;
            WOvf  <= 1'b0;
            WUnf  <= 1'b0;
            WErr  <= 1'b0;
        end else begin
            WOvf <= 1'b0;
            WUnf <= 1'b0;
            WErr <= 1'b0;
            if (CwpLd) begin
                cwp_q <= load_val;
            end else if (Save && Restore) begin
                WErr <= 1'b1;
            end else if (Save) begin
                if (wim_save[0]) WOvf <= 1'b1;
                else             cwp_q <= save_tgt;
            end else if (Restore) begin
                if (wim_rest[0]) WUnf <= 1'b1;
                else             cwp_q <= rest_tgt;
            end
        end
    end

    assign CWP = cwp_q;

endmodule

// File: rtl/windowed_regfile.sv
// Windowed register file: 8 globals plus NWINDOWS overlapping 16-register
// windows, two combinational read ports and one write port.
module windowed_regfile
    import windowed_regfile_pkg::*;
#(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CWPW     = 5
) (
    input  logic                Clk,
    input  logic                Clr_n,
    input  logic [AW-1:0]       RA,
    input  logic [AW-1:0]       RB,
    output logic [WIDTH-1:0]    PortA,
    output logic [WIDTH-1:0]    PortB,
    input  logic [AW-1:0]       RC,
    input  logic [WIDTH-1:0]    PortC,
    input  logic                Ld,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CwpLd,
    input  logic [CWPW-1:0]     CwpIn,
    input  logic [NWINDOWS-1:0] WIM,
    output logic [CWPW-1:0]     CWP,
    output logic                WOvf,
    output logic                WUnf,
    output logic                WErr
);

    localparam int unsigned NWREGS = NWINDOWS * WINREGS;
    localparam int unsigned IW     = $clog2(NWREGS);

    logic [WIDTH-1:0] gregs [NGLOBALS];
    logic [WIDTH-1:0] wregs [NWREGS];
    logic [CWPW-1:0]  cwp;
    logic [IW-1:0]    a_idx;
    logic [IW-1:0]    b_idx;
    logic [IW-1:0]    c_idx;

    windowed_regfile_cwp #(
        .NWINDOWS (NWINDOWS),
        .CWPW     (CWPW)
    ) u_cwp (
        .Clk     (Clk),
        .Clr_n   (Clr_n),
        .Save    (Save),
        .Restore (Restore),
        .CwpLd   (CwpLd),
        .CwpIn   (CwpIn),
        .WIM     (WIM),
        .CWP     (cwp),
        .WOvf    (WOvf),
        .WUnf    (WUnf),
        .WErr    (WErr)
    );

    assign CWP   = cwp;
    assign a_idx = IW'(win_index(32'(cwp), 32'(RA), NWINDOWS));
    assign b_idx = IW'(win_index(32'(cwp), 32'(RB), NWINDOWS));
    assign c_idx = IW'(win_index(32'(cwp), 32'(RC), NWINDOWS));

    always_comb begin
        PortA = '0;
        if (RA != '0) begin
            if (RA < AW'(NGLOBALS)) PortA = gregs[RA[2:0]];
            else                    PortA = wregs[a_idx];
        end
    end

    always_comb begin
        PortB = '0;
        if (RB != '0) begin
            if (RB < AW'(NGLOBALS)) PortB = gregs[RB[2:0]];
            else                    PortB = wregs[b_idx];
        end
    end

    // The write index uses the pre-update CWP, so a write sharing a cycle
    // with a window change lands in the old window.
    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            for (int unsigned i = 0; i < NGLOBALS; i++) gregs[i] <= '0;
            for (int unsigned i = 0; i < NWREGS; i++)   wregs[i] <= '0;
        end else if (Ld && RC != '0) begin
            if (RC < AW'(NGLOBALS)) gregs[RC[2:0]] <= PortC;
            else                    wregs[c_idx]   <= PortC;
        end
    end

endmodule

// File: tb/tb_windowed_regfile.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural register-window model.
module tb_windowed_regfile;

    localparam int NW = 8;

    logic          Clk = 1'b0;
    logic          Clr_n = 1'b0;
    logic [4:0]    RA = '0, RB = '0, RC = '0;
    logic [31:0]   PortA, PortB, PortC = '0;
    logic          Ld = 1'b0, Save = 1'b0, Restore = 1'b0, CwpLd = 1'b0;
    logic [4:0]    CwpIn = '0;
    logic [NW-1:0] WIM = '0;
    logic [4:0]    CWP;
    logic          WOvf, WUnf, WErr;

    int errors = 0;
    int checks = 0;

    windowed_regfile #(
        .NWINDOWS (NW),
        .WIDTH    (32),
        .CWPW     (5)
    ) dut (
        .Clk     (Clk),
        .Clr_n   (Clr_n),
        .RA      (RA),
        .RB      (RB),
        .PortA   (PortA),
        .PortB   (PortB),
        .RC      (RC),
        .PortC   (PortC),
        .Ld      (Ld),
        .Save    (Save),
        .Restore (Restore),
        .CwpLd   (CwpLd),
        .CwpIn   (CwpIn),
        .WIM     (WIM),
        .CWP     (CWP),
        .WOvf    (WOvf),
        .WUnf    (WUnf),
        .WErr    (WErr)
    );

    always #5 Clk = ~Clk;

    // Model: a window is 16 registers starting at 16*cwp in a circular pool,
    // so r24..r31 of window w-1 are the same cells as r8..r15 of window w.
    logic [31:0] mg [8];
    logic [31:0] mw [NW*16];
    int          mcwp = 0;
    bit          movf = 0, munf = 0, merr = 0;
    bit          mvalid = 0;

    function automatic logic [31:0] mread(input int r);
        if (r == 0) return 32'h0;
        if (r < 8)  return mg[r];
        return mw[(mcwp * 16 + (r - 8)) % (NW * 16)];
    endfunction

    always @(posedge Clk) begin
        if (!Clr_n) begin
            foreach (mg[i]) mg[i] = '0;
            foreach (mw[i]) mw[i] = '0;
            mcwp = 0; movf = 0; munf = 0; merr = 0;
            mvalid = 1;
        end else begin
            int up, dn;
            movf = 0; munf = 0; merr = 0;
            if (Ld && RC != 0) begin
                if (RC < 8) mg[RC] = PortC;
                else        mw[(mcwp * 16 + (int'(RC) - 8)) % (NW * 16)] = PortC;
            end
            dn = (mcwp + NW - 1) % NW;
            up = (mcwp + 1) % NW;
            if (CwpLd)                mcwp = int'(CwpIn) % NW;
            else if (Save && Restore) merr = 1;
            else if (Save) begin
                if (WIM[dn]) movf = 1; else mcwp = dn;
            end else if (Restore) begin
                if (WIM[up]) munf = 1; else mcwp = up;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (mvalid) begin
            chk("cwp",   32'(CWP),   32'(mcwp));
            chk("wovf",  32'(WOvf),  32'(movf));
            chk("wunf",  32'(WUnf),  32'(munf));
            chk("werr",  32'(WErr),  32'(merr));
            chk("porta", PortA, mread(int'(RA)));
            chk("portb", PortB, mread(int'(RB)));
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Ld = 0; Save = 0; Restore = 0; CwpLd = 0;
    endtask

    task automatic load_cwp(input int v);
        idle(); CwpLd = 1; CwpIn = 5'(v); cyc(); CwpLd = 0;
    endtask

    task automatic peek(input string name, input int r, input logic [31:0] exp);
        RA = 5'(r); #1;
        chk(name, PortA, exp);
    endtask

    initial begin
        Clr_n = 0; cyc(); cyc();
        Clr_n = 1; idle(); WIM = '0;

        chk("reset_cwp", 32'(CWP), 32'd0);
        chk("reset_pulses", {29'd0, WOvf, WUnf, WErr}, 32'd0);
        for (int r = 0; r < 32; r++) begin
            RA = 5'(r); RB = 5'(31 - r); #1;
            chk("reset_read_a", PortA, 32'h0);
            chk("reset_read_b", PortB, 32'h0);
        end

        // Outs of window 0 become ins of window 7 after a save.
        Ld = 1; RC = 5'd8; PortC = 32'hAAAA0008; cyc(); idle();
        Save = 1; cyc(); idle();
        chk("save_cwp7", 32'(CWP), 32'd7);
        peek("save_alias_r24", 24, 32'hAAAA0008);

        load_cwp(0);
        WIM = 8'h80; Save = 1; cyc(); idle();
        chk("ovf_cwp", 32'(CWP), 32'd0);
        chk("ovf_pulse", 32'(WOvf), 32'd1);
        cyc();
        chk("ovf_single", 32'(WOvf), 32'd0);
        WIM = 8'h02; Restore = 1; cyc(); idle();
        chk("unf_cwp", 32'(CWP), 32'd0);
        chk("unf_pulse", 32'(WUnf), 32'd1);
        cyc();
        chk("unf_single", 32'(WUnf), 32'd0);

        WIM = '0;
        Ld = 1; RC = 5'd3; PortC = 32'h1234; cyc(); idle();
        load_cwp(5);
        chk("load_cwp5", 32'(CWP), 32'd5);
        peek("global_r3", 3, 32'h1234);
        Ld = 1; RC = 5'd0; PortC = 32'hFFFF; cyc(); idle();
        peek("r0_zero", 0, 32'h0);

        Save = 1; Restore = 1; cyc(); idle();
        chk("err_pulse", 32'(WErr), 32'd1);
        chk("err_cwp", 32'(CWP), 32'd5);
        Save = 1; CwpLd = 1; CwpIn = 5'd2; WIM = 8'hFF; cyc(); idle();
        chk("ld_prio_cwp", 32'(CWP), 32'd2);
        chk("ld_prio_noovf", 32'(WOvf), 32'd0);
        load_cwp(13);
        chk("ld_mod", 32'(CWP), 32'd5);

        WIM = '0;
        load_cwp(7); Restore = 1; cyc(); idle();
        chk("wrap_restore", 32'(CWP), 32'd0);

        load_cwp(3);
        Ld = 1; RC = 5'd16; PortC = 32'h55; Save = 1; cyc(); idle();
        chk("wr_save_cwp", 32'(CWP), 32'd2);
        load_cwp(3);
        peek("wr_old_window", 16, 32'h55);

        load_cwp(0);
        WIM = 8'h80; Save = 1; cyc();
        chk("pend_ovf", 32'(WOvf), 32'd1);
        Clr_n = 0; load_cwp(4);
        cyc();
        Clr_n = 1; Save = 1; WIM = 8'h00; cyc(); idle();
        Clr_n = 0; Save = 1; cyc(); idle();
        chk("rst_pending_cwp", 32'(CWP), 32'd0);
        chk("rst_pending_ovf", 32'(WOvf), 32'd0);
        Clr_n = 1;
        peek("rst_cleared_r16", 16, 32'h0);

        for (int n = 0; n < 2000; n++) begin
            Clr_n   = ($urandom_range(0, 99) != 0);
            Ld      = $urandom_range(0, 1);
            RC      = 5'($urandom_range(0, 31));
            PortC   = $urandom;
            Save    = ($urandom_range(0, 3) == 0);
            Restore = ($urandom_range(0, 3) == 0);
            CwpLd   = ($urandom_range(0, 15) == 0);
            CwpIn   = 5'($urandom_range(0, 31));
            WIM     = NW'($urandom & $urandom);
            RA      = 5'($urandom_range(0, 31));
            RB      = 5'($urandom_range(0, 31));
            cyc();
        end

        idle(); Clr_n = 1; cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
